param_updown_counter: RTL and testbench
=======================================

// Module: param_updown_counter
// PURPOSE
//  Synchronous, fully parametrised up/down counter with programmable modulus,
//  load, sync clear, wrap-or-saturate mode and an optional clock-enable prescaler.
//  Next-generation replacement for the fixed 4-bit ripple counter.
//  All flops share one clock, so the block is safe for timers, event counters and
//  address sequencers in the same clock domain.
// PARAMETERS
//  WIDTH     8    counter width in bits, >=1
//  MAX_VAL   255  terminal value; count range is 0..MAX_VAL; must be < 2**WIDTH
//  SATURATE  0    0 = wrap at the boundary, 1 = hold at the boundary
//  PRESCALE  1    count once every PRESCALE enabled cycles; >=1; 1 = no prescale
// PORTS
//  clk       in   1      clock, rising edge
//  rst       in   1      reset, asynchronous, active-high
//  en        in   1      count enable; low freezes the count and the prescaler
//  up_dn     in   1      1 = count up, 0 = count down; sampled on each tick
//  clr       in   1      synchronous clear
//  load      in   1      synchronous load of load_val
//  load_val  in   WIDTH  value to load
//  count     out  WIDTH  current count, registered
//  tc        out  1      terminal-count pulse, registered, high for exactly 1 cycle
//  ovf       out  1      sticky boundary flag, registered
// BEHAVIOUR
//  - Reset (async): count=0, tc=0, ovf=0, prescaler phase=0.
//  - tick = en & (prescaler phase == PRESCALE-1). The phase counts 0..PRESCALE-1
//    on enabled cycles and wraps. With PRESCALE=1, tick = en.
//  - Per-cycle priority: clr > load > tick > hold.
//  - clr:  count<=0, ovf<=0, tc<=0, phase<=0.
//  - load: count<=min(load_val, MAX_VAL), phase<=0, tc<=0; ovf is unchanged.
//  - tick, up, count<MAX_VAL:   count<=count+1.
//  - tick, up, count==MAX_VAL:  count<=0 (SATURATE=0) or count holds (SATURATE=1);
//    tc<=1; ovf<=1.
//  - tick, down, count>0:       count<=count-1.
//  - tick, down, count==0:      count<=MAX_VAL (SATURATE=0) or count holds
//    (SATURATE=1); tc<=1; ovf<=1.
//  - tc is high in the same cycle that count shows the post-boundary value.
//    tc is 0 in every other cycle.
//  - In saturate mode, every tick at the boundary re-pulses tc.
//    There is no pulse-once latch.
//  - en low: count, phase and tc are held at 0 pulse (tc=0). clr and load still act.
//  - Latency: 1 cycle from the qualifying input edge to count, tc and ovf.
//  - Width: arithmetic is done at WIDTH bits. MAX_VAL is not required to be 2**WIDTH-1;
//    the compare is always against MAX_VAL, never against natural overflow.
//  - Elaboration error if MAX_VAL >= 2**WIDTH or PRESCALE < 1.
//  - rst asserted mid-count clears everything immediately.
//    The first tick after deassertion needs a full PRESCALE enabled cycles.
// STRUCTURE
//  - Shared header counter_defs.vh holds:
//    `CNT_MODE_WRAP = 0 and `CNT_MODE_SAT = 1;
//    a clog2 function macro used to size the prescaler phase register.
//  - Sub-module tick_prescaler: params PRESCALE; ports clk, rst, en, sync_clr, tick.
//    When PRESCALE==1 it reduces to a wire via generate.
//  - The top level holds the count, tc and ovf registers and the next-state mux.
// TESTING
//  1. WIDTH=4, MAX_VAL=15, SATURATE=0, PRESCALE=1:
//     rst pulse, en=1, up=1 for 18 clk -> 0,1..15,0,1.
//     tc high only on the cycle count=0 after 15; ovf=1 from then on.
//  2. MAX_VAL=9, down, start 0 -> 9,8..0,9. tc pulses on each 0->9 transition.
//  3. SATURATE=1, MAX_VAL=9, load_val=8, up -> 9,9,9. tc is high on the 2nd and 3rd
//     ticks; down then gives 8 with tc=0.
//  4. PRESCALE=3, en=1 -> count increments every 3rd cycle.
//     Dropping en for 2 cycles mid-phase stretches the interval to exactly 5 cycles.
//  5. Priority: clr=load=en=1 same cycle -> count=0, ovf=0.
//     load=1, load_val=15 with MAX_VAL=9 -> count=9.
//  6. Assert rst asynchronously between clock edges while count=7 -> count=0, tc=0, ovf=0
//     immediately. After release, counting resumes from 0 on the next tick.

Source files
------------

// File: rtl/param_updown_counter_pkg.sv
// Shared definitions for the parametrised up/down counter: boundary modes and
// the width helper used to size the prescaler phase register.
package param_updown_counter_pkg;

  localparam int CNT_MODE_WRAP = 0;
  localparam int CNT_MODE_SAT  = 1;

  // Bits needed to hold 0..value-1, never less than one.
  function automatic int clog2_min1(input int value);
    int w;
    w = 1;
    while ((longint'(1) << w) < longint'(value)) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/param_updown_counter_tick_prescaler.sv
// Clock-enable prescaler: emits one tick every PRESCALE enabled cycles.
// With PRESCALE == 1 it collapses to a plain wire from en to tick.
module tick_prescaler
  import param_updown_counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic sync_clr,
  output logic tick
);

  generate
    if (PRESCALE <= 1) begin : g_bypass
      logic unused_ok;
      assign unused_ok = ^{clk, rst, sync_clr};
      assign tick      = en;
    end else begin : g_div
      localparam int            PW   = clog2_min1(PRESCALE);
      localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

      logic [PW-1:0] phase_q;
      logic [PW-1:0] phase_d;
      logic          at_last;

      assign at_last = (phase_q == LAST);

      // Phase only advances on enabled cycles, so a gap in en stretches the interval.
      always_comb begin
        phase_d = phase_q;
        if (sync_clr) begin
          phase_d = '0;
        end else if (en) begin
          phase_d = at_last ? '0 : phase_q + PW'(1);
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          phase_q <= '0;
        end else begin
          phase_q <= phase_d;
        end
      end

      assign tick = en & at_last;
    end
  endgenerate

endmodule

// File: rtl/param_updown_counter.sv
// Parametrised up/down counter with programmable terminal value, load, sync
// clear, wrap-or-saturate boundary handling and an optional tick prescaler.
module param_updown_counter
  import param_updown_counter_pkg::*;
#(
  parameter int          WIDTH    = 8,
  parameter int unsigned MAX_VAL  = 255,
  parameter int          SATURATE = CNT_MODE_WRAP,
  parameter int          PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  generate
    if ((WIDTH < 1) || (longint'(MAX_VAL) >= (longint'(1) << WIDTH)) || (PRESCALE < 1))
    begin : g_bad_params
      $error("param_updown_counter: need WIDTH>=1, MAX_VAL < 2**WIDTH and PRESCALE >= 1");
    end
  endgenerate

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);
  localparam bit               SAT   = (SATURATE == CNT_MODE_SAT);

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             tick;
  logic [WIDTH-1:0] load_clip;

  // Clear and load both restart the prescaler so the next tick is a full period away.
  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .sync_clr (clr | load),
    .tick     (tick)
  );

  assign load_clip = (load_val > MAX_W) ? MAX_W : load_val;

  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    ovf_d   = ovf_q;
    if (clr) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (load) begin
      count_d = load_clip;
    end else if (tick) begin
      if (up_dn) begin
        if (count_q == MAX_W) begin
          count_d = SAT ? count_q : '0;
          tc_d    = 1'b1;
          ovf_d   = 1'b1;
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end else begin
        if (count_q == '0) begin
          count_d = SAT ? count_q : MAX_W;
          tc_d    = 1'b1;
          ovf_d   = 1'b1;
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_param_updown_counter.sv
// Directed bench for param_updown_counter: four instances with different
// parameter sets share one stimulus stream; each phase checks one instance.
module tb_param_updown_counter;

  logic       clk;
  logic       rst;
  logic       en;
  logic       up_dn;
  logic       clr;
  logic       load;
  logic [3:0] load_val;

  logic [3:0] cnt_a, cnt_b, cnt_c, cnt_d;
  logic       tc_a, tc_b, tc_c, tc_d;
  logic       ovf_a, ovf_b, ovf_c, ovf_d;

  int total = 0;
  int bad   = 0;

  // a: 4-bit wrap, b: mod-10 wrap, c: mod-10 saturate, d: 4-bit wrap with /3 prescale
  param_updown_counter #(.WIDTH(4), .MAX_VAL(15), .SATURATE(0), .PRESCALE(1)) u_a (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val), .count(cnt_a), .tc(tc_a), .ovf(ovf_a));
  param_updown_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(0), .PRESCALE(1)) u_b (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val), .count(cnt_b), .tc(tc_b), .ovf(ovf_b));
  param_updown_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1), .PRESCALE(1)) u_c (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val), .count(cnt_c), .tc(tc_c), .ovf(ovf_c));
  param_updown_counter #(.WIDTH(4), .MAX_VAL(15), .SATURATE(0), .PRESCALE(3)) u_d (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val), .count(cnt_d), .tc(tc_d), .ovf(ovf_d));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; up_dn = 1'b1; clr = 1'b0; load = 1'b0; load_val = '0;

    // Reset state
    #2 rst = 1'b1;
    #2;
    chk("rst_count", cnt_a, 0);
    chk("rst_tc", tc_a, 0);
    chk("rst_ovf", ovf_a, 0);
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b1;

    // Count up through the 15 -> 0 wrap
    for (int k = 1; k <= 17; k++) begin
      step();
      chk($sformatf("up_count_%0d", k), cnt_a, k % 16);
      chk($sformatf("up_tc_%0d", k), tc_a, (k == 16) ? 1 : 0);
      chk($sformatf("up_ovf_%0d", k), ovf_a, (k >= 16) ? 1 : 0);
    end

    // Mod-10 count down from 0
    clr = 1'b1;
    step();
    chk("clr_count_b", cnt_b, 0);
    chk("clr_ovf_b", ovf_b, 0);
    clr   = 1'b0;
    up_dn = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      step();
      chk($sformatf("dn_count_%0d", k), cnt_b, (10 - (k % 10)) % 10);
      chk($sformatf("dn_tc_%0d", k), tc_b, (k == 1 || k == 11) ? 1 : 0);
      chk($sformatf("dn_ovf_%0d", k), ovf_b, 1);
    end

    // Saturate at 9, tc re-pulses on every boundary tick
    up_dn = 1'b1; load = 1'b1; load_val = 4'd8;
    step();
    chk("sat_load", cnt_c, 8);
    chk("sat_load_tc", tc_c, 0);
    load = 1'b0;
    step();
    chk("sat_t1_count", cnt_c, 9);
    chk("sat_t1_tc", tc_c, 0);
    step();
    chk("sat_t2_count", cnt_c, 9);
    chk("sat_t2_tc", tc_c, 1);
    step();
    chk("sat_t3_count", cnt_c, 9);
    chk("sat_t3_tc", tc_c, 1);
    chk("sat_ovf", ovf_c, 1);
    up_dn = 1'b0;
    step();
    chk("sat_dn_count", cnt_c, 8);
    chk("sat_dn_tc", tc_c, 0);

    // Prescale by 3, then a 2-cycle en gap mid-phase
    up_dn = 1'b1; clr = 1'b1;
    step();
    chk("pre_clr", cnt_d, 0);
    clr = 1'b0;
    step(); chk("pre_e1", cnt_d, 0);
    step(); chk("pre_e2", cnt_d, 0);
    step(); chk("pre_e3", cnt_d, 1);
    step(); chk("pre_e4", cnt_d, 1);
    step(); chk("pre_e5", cnt_d, 1);
    step(); chk("pre_e6", cnt_d, 2);
    step(); chk("pre_e7", cnt_d, 2);
    en = 1'b0;
    step(); chk("pre_gap1", cnt_d, 2);
    step(); chk("pre_gap2", cnt_d, 2);
    en = 1'b1;
    step(); chk("pre_e10", cnt_d, 2);
    step(); chk("pre_e11", cnt_d, 3);
    chk("pre_tc", tc_d, 0);

    // Priority: clr beats load; load clips to MAX_VAL and leaves ovf alone
    clr = 1'b1; load = 1'b1; load_val = 4'd5;
    step();
    chk("prio_count", cnt_b, 0);
    chk("prio_ovf", ovf_b, 0);
    clr = 1'b0; load_val = 4'd15;
    step();
    chk("clip_count", cnt_b, 9);
    chk("clip_ovf", ovf_b, 0);
    load = 1'b0;
    step();
    chk("wrap9_count", cnt_b, 0);
    chk("wrap9_tc", tc_b, 1);
    chk("wrap9_ovf", ovf_b, 1);
    load = 1'b1; load_val = 4'd3;
    step();
    chk("load_keep_count", cnt_b, 3);
    chk("load_keep_ovf", ovf_b, 1);
    chk("load_keep_tc", tc_b, 0);

    // Async reset mid-count with ovf set
    load_val = 4'd15;
    step();
    load = 1'b0;
    step();
    chk("pre_rst_ovf", ovf_a, 1);
    load = 1'b1; load_val = 4'd7;
    step();
    chk("pre_rst_count", cnt_a, 7);
    load = 1'b0; en = 1'b0;
    #3 rst = 1'b1;
    #1;
    chk("async_count", cnt_a, 0);
    chk("async_tc", tc_a, 0);
    chk("async_ovf", ovf_a, 0);
    #2 rst = 1'b0;
    en = 1'b1; up_dn = 1'b1;
    step();
    chk("resume_count", cnt_a, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
